// File: rtl/zeroriscy_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_rf_write_arbiter
// Description : Shares the register file's single write port between the EX
//               stage and the LSU load-return path (LSU has priority). Holds
//               a scoreboard of outstanding load destinations and raises
//               read stalls for ID while a register value is still in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 core clock
//   rst_n               asynchronous reset, active low
//   ex_valid_i          EX write request
//   ex_ready_o          EX request accepted when valid & ready
//   ex_waddr_i          EX destination register
//   ex_wdata_i          EX result
//   lsu_issue_i         load issued (qualified by lsu_issue_ready_o)
//   lsu_issue_rd_i      destination of the issued load
//   lsu_issue_ready_o   a load may issue this cycle
//   lsu_valid_i         load data return (no backpressure)
//   lsu_kill_i          load terminated with bus error, no write
//   lsu_rd_i            destination of the returning/killed load
//   lsu_rdata_i         load data
//   raddr_a_i/raddr_b_i ID read addresses
//   stall_a_o/stall_b_o operand hazards
//   rf_we_o/rf_waddr_o/rf_wdata_o  registered RF write port
//   protocol_err_o      sticky protocol violation flag
// ============================================================================
module zeroriscy_rf_write_arbiter #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_issue_i,
  input  logic [ADDR_WIDTH-1:0] lsu_issue_rd_i,
  output logic                  lsu_issue_ready_o,
  input  logic                  lsu_valid_i,
  input  logic                  lsu_kill_i,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  stall_a_o,
  output logic                  stall_b_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  protocol_err_o
);

  localparam int c_NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int c_CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  // Bit 0 of the scoreboard is never set: x0 cannot be a hazard.
  logic [c_NUM_WORDS-1:0] r_pending;
  logic [c_NUM_WORDS-1:0] w_pending_nxt;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_CNT_W-1:0]     w_count_nxt;

  logic                   r_hold_valid;
  logic [ADDR_WIDTH-1:0]  r_hold_addr;
  logic [DATA_WIDTH-1:0]  r_hold_data;

  logic                   r_rf_we;
  logic [ADDR_WIDTH-1:0]  r_rf_waddr;
  logic [DATA_WIDTH-1:0]  r_rf_wdata;
  logic                   r_protocol_err;

  logic w_lsu_wr;      // load return that actually writes
  logic w_lsu_done;    // load retires (return or kill)
  logic w_ex_accept;
  logic w_issue;
  logic w_can_dec;
  logic w_proto_viol;

  assign w_lsu_wr    = lsu_valid_i & ~lsu_kill_i;
  assign w_lsu_done  = lsu_valid_i | lsu_kill_i;
  assign w_can_dec   = w_lsu_done & (r_count != '0);

  // WAW against an outstanding load stalls EX so the older load lands first.
  assign ex_ready_o  = ~r_hold_valid & ~r_pending[ex_waddr_i];
  assign w_ex_accept = ex_valid_i & ex_ready_o;

  assign lsu_issue_ready_o = (r_count < c_MAX_CNT) &
                             ((lsu_issue_rd_i == '0) | ~r_pending[lsu_issue_rd_i]);
  assign w_issue = lsu_issue_i & lsu_issue_ready_o;

  assign w_proto_viol = w_lsu_done &
                        ((r_count == '0) | ((lsu_rd_i != '0) & ~r_pending[lsu_rd_i]));

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_lsu_done) begin
      w_pending_nxt[lsu_rd_i] = 1'b0;
    end
    if (w_issue && (lsu_issue_rd_i != '0)) begin
      w_pending_nxt[lsu_issue_rd_i] = 1'b1;
    end
  end

  // Count saturates at zero on an unmatched return/kill.
  always_comb begin
    w_count_nxt = r_count;
    if (w_issue && !w_can_dec) begin
      w_count_nxt = r_count + c_ONE;
    end else if (!w_issue && w_can_dec) begin
      w_count_nxt = r_count - c_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_count        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_pending      <= w_pending_nxt;
      r_count        <= w_count_nxt;
      r_protocol_err <= r_protocol_err | w_proto_viol;
    end
  end

  // Output stage: LSU write > held EX result > newly accepted EX result.
  // An EX result accepted while the LSU owns the port parks in the hold
  // register; since hold blocks ex_ready_o, EX order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
    end else begin
      if (w_lsu_wr) begin
        r_rf_we    <= (lsu_rd_i != '0);
        r_rf_waddr <= lsu_rd_i;
        r_rf_wdata <= lsu_rdata_i;
        if (w_ex_accept) begin
          r_hold_valid <= 1'b1;
          r_hold_addr  <= ex_waddr_i;
          r_hold_data  <= ex_wdata_i;
        end
      end else if (r_hold_valid) begin
        r_rf_we      <= (r_hold_addr != '0);
        r_rf_waddr   <= r_hold_addr;
        r_rf_wdata   <= r_hold_data;
        r_hold_valid <= 1'b0;
      end else if (w_ex_accept) begin
        r_rf_we    <= (ex_waddr_i != '0);
        r_rf_waddr <= ex_waddr_i;
        r_rf_wdata <= ex_wdata_i;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  // A value is not readable from the RF until the cycle after rf_we_o.
  assign stall_a_o = (raddr_a_i != '0) &
                     (r_pending[raddr_a_i] |
                      (r_hold_valid & (r_hold_addr == raddr_a_i)) |
                      (r_rf_we & (r_rf_waddr == raddr_a_i)));
  assign stall_b_o = (raddr_b_i != '0) &
                     (r_pending[raddr_b_i] |
                      (r_hold_valid & (r_hold_addr == raddr_b_i)) |
                      (r_rf_we & (r_rf_waddr == raddr_b_i)));

  assign rf_we_o        = r_rf_we;
  assign rf_waddr_o     = r_rf_waddr;
  assign rf_wdata_o     = r_rf_wdata;
  assign protocol_err_o = r_protocol_err;

endmodule
`default_nettype wire
